// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: select codes, stage states
// and the per-entry record that travels with each captured result.
package alu_pkg;

  // Result-select codes, identical to the 4-to-1 result mux select.
  localparam int unsigned SEL_W_PKG = 2;
  localparam logic [SEL_W_PKG-1:0] SEL_ARITH = 2'b00;
  localparam logic [SEL_W_PKG-1:0] SEL_LOGIC = 2'b01;
  localparam logic [SEL_W_PKG-1:0] SEL_SHIFT = 2'b10;
  localparam logic [SEL_W_PKG-1:0] SEL_CMP   = 2'b11;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no entries
    ST_ONE   = 2'd1,  // main entry valid
    ST_FULL  = 2'd2   // main and skid entries valid
  } state_e;

  // Everything stored alongside a result. The result itself is kept in a
  // WIDTH-sized register next to this record so the datapath width stays
  // a module parameter.
  typedef struct packed {
    logic [SEL_W_PKG-1:0] sel;
    logic                 zero;
    logic                 neg;
    logic                 carry;
    logic                 ovf;
  } entry_meta_t;

  // Carry/overflow only carry meaning for adder results.
  function automatic logic is_arith(input logic [SEL_W_PKG-1:0] sel);
    return sel == SEL_ARITH;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generation for a freshly selected ALU result.
// zero/neg come from the result bits; carry/ovf are passed through only for
// arithmetic results and forced low for every other select.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic [WIDTH-1:0] result,
  input  logic [SEL_W-1:0] sel,
  input  logic             carry_raw,
  input  logic             ovf_raw,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf
);

  logic arith;

  // Derive flags and mask adder-only flags by the select code.
  always_comb begin
    arith = (sel == SEL_W'(SEL_ARITH));
    zero  = (result == '0);
    neg   = result[WIDTH-1];
    carry = arith & carry_raw;
    ovf   = arith & ovf_raw;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU result mux. Each accepted result is
// captured together with its select code and status flags into a 2-entry
// skid buffer (main + skid). The out_* ports are driven from the main entry
// only. A saturating counter tracks delivered results for debug.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready is a register that is high exactly when the skid entry is
// empty, so it never depends combinationally on out_ready; upstream holds its
// data while in_ready is low. out_* hold stable while out_valid & !out_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] done_cnt
);

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  main_result_q;
  logic [WIDTH-1:0]  skid_result_q;
  entry_meta_t       main_meta_q;
  entry_meta_t       skid_meta_q;
  entry_meta_t       new_meta;
  logic [CNT_W-1:0]  done_cnt_q;

  logic              f_zero;
  logic              f_neg;
  logic              f_carry;
  logic              f_ovf;
  logic              in_fire;
  logic              out_fire;

  // Flags are computed once, at capture time, and stored with the entry.
  alu_flag_gen #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_flag_gen (
    .result    (in_result),
    .sel       (in_sel),
    .carry_raw (in_carry),
    .ovf_raw   (in_ovf),
    .zero      (f_zero),
    .neg       (f_neg),
    .carry     (f_carry),
    .ovf       (f_ovf)
  );

  // Assemble the record for an incoming result and decode the two transfers.
  always_comb begin
    new_meta       = '0;
    new_meta.sel   = SEL_W_PKG'(in_sel);
    new_meta.zero  = f_zero;
    new_meta.neg   = f_neg;
    new_meta.carry = f_carry;
    new_meta.ovf   = f_ovf;
    in_fire        = in_valid & in_ready_q;
    out_fire       = out_valid_q & out_ready;
  end

  // Skid-buffer FSM: occupancy state, registered handshakes and entry data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      main_result_q <= '0;
      main_meta_q   <= '0;
      skid_result_q <= '0;
      skid_meta_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_result_q <= in_result;
            main_meta_q   <= new_meta;
            out_valid_q   <= 1'b1;
            state_q       <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({in_fire, out_fire})
            2'b10: begin
              // Downstream stalled: park the new result in the skid entry.
              skid_result_q <= in_result;
              skid_meta_q   <= new_meta;
              in_ready_q    <= 1'b0;
              state_q       <= ST_FULL;
            end
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= ST_EMPTY;
            end
            2'b11: begin
              // Main drains and refills in the same edge: full throughput.
              main_result_q <= in_result;
              main_meta_q   <= new_meta;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          if (out_fire) begin
            main_result_q <= skid_result_q;
            main_meta_q   <= skid_meta_q;
            in_ready_q    <= 1'b1;
            state_q       <= ST_ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to an empty buffer.
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= ST_EMPTY;
        end
      endcase
    end
  end

  // Saturating count of completed output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (out_fire && (done_cnt_q != {CNT_W{1'b1}})) begin
      done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  // Outputs come straight from registers; main entry only.
  always_comb begin
    in_ready   = in_ready_q;
    out_valid  = out_valid_q;
    out_result = main_result_q;
    out_sel    = SEL_W'(main_meta_q.sel);
    out_zero   = main_meta_q.zero;
    out_neg    = main_meta_q.neg;
    out_carry  = main_meta_q.carry;
    out_ovf    = main_meta_q.ovf;
    done_cnt   = done_cnt_q;
  end

endmodule
